spi_dac_frame_receiver: RTL and testbench

- SPI slave receiver for the 3-wire DAC frame format: SCLK, SYNC_n, DIN, 16 bits, MSB first.
- Bits 15:14 are don't-care, 13:12 are mode, 11:0 are data.
- Runs in the clock_50Mhz domain and oversamples the external pins.
- Used as a loopback checker and on-board DAC model behind the SPI DAC output controller, and as an input port when another board drives the same interface.

---
 rtl/spi_dac_frame_receiver.sv | 156 +++++++++++++++
 tb/tb_spi_dac_frame_receiver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_frame_receiver.sv
// SPI DAC frame receiver: oversamples SCLK/SYNC_n/DIN in the 50 MHz domain and latches 16-bit frames.
// Define SPI_RX_FRAME_STATS_EN to add good/error frame counters.
module spi_dac_frame_receiver #(
  parameter int unsigned SAMPLE_ON_RISING = 1,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic        clock_50Mhz,
  input  logic        reset_n,
  input  logic        input_SPI_SCLK,
  input  logic        input_SPI_SYNC_n,
  input  logic        input_SPI_DIN,
  output logic [11:0] outputSample,
  output logic [1:0]  outputMode,
  output logic        sampleValid,
  output logic        frameError,
  output logic        isReceiving
`ifdef SPI_RX_FRAME_STATS_EN
  ,
  output logic [15:0] goodFrameCount,
  output logic [15:0] errorFrameCount
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  logic [SYNC_STAGES-1:0] sclkSync_q;
  logic [SYNC_STAGES-1:0] syncnSync_q;
  logic [SYNC_STAGES-1:0] dinSync_q;
  logic                   sclkPrev_q;
  logic                   syncnPrev_q;

  logic sclkNow;
  logic syncnNow;
  logic dinNow;
  logic sampleEdge;
  logic syncRise;
  logic syncFall;

  state_e      state_q;
  logic [4:0]  bitCount_q;
  logic [12:0] shift_q;
  logic [13:0] shiftNext_d;
  logic [11:0] outputSample_q;
  logic [1:0]  outputMode_q;
  logic        validPending_q;
  logic        sampleValid_q;
  logic        frameError_q;

  // SYNC_n resets to its idle-high level so releasing reset never fakes a frame start.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      sclkSync_q  <= '0;
      syncnSync_q <= '1;
      dinSync_q   <= '0;
      sclkPrev_q  <= 1'b0;
      syncnPrev_q <= 1'b1;
    end else begin
      sclkSync_q  <= {sclkSync_q[SYNC_STAGES-2:0], input_SPI_SCLK};
      syncnSync_q <= {syncnSync_q[SYNC_STAGES-2:0], input_SPI_SYNC_n};
      dinSync_q   <= {dinSync_q[SYNC_STAGES-2:0], input_SPI_DIN};
      sclkPrev_q  <= sclkSync_q[SYNC_STAGES-1];
      syncnPrev_q <= syncnSync_q[SYNC_STAGES-1];
    end
  end

  assign sclkNow  = sclkSync_q[SYNC_STAGES-1];
  assign syncnNow = syncnSync_q[SYNC_STAGES-1];
  assign dinNow   = dinSync_q[SYNC_STAGES-1];
  assign syncRise = syncnNow & ~syncnPrev_q;
  assign syncFall = ~syncnNow & syncnPrev_q;

  if (SAMPLE_ON_RISING != 0) begin : g_sampleRise
    assign sampleEdge = sclkNow & ~sclkPrev_q;
  end else begin : g_sampleFall
    assign sampleEdge = ~sclkNow & sclkPrev_q;
  end

  // Only the low 14 frame bits are ever used, so the don't-care bits 15:14 are never stored.
  assign shiftNext_d = {shift_q, dinNow};

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      bitCount_q     <= '0;
      shift_q        <= '0;
      outputSample_q <= '0;
      outputMode_q   <= '0;
      validPending_q <= 1'b0;
      sampleValid_q  <= 1'b0;
      frameError_q   <= 1'b0;
    end else begin
      sampleValid_q  <= validPending_q;
      validPending_q <= 1'b0;
      frameError_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (syncFall) begin
            state_q    <= SHIFT;
            bitCount_q <= '0;
          end
        end
        SHIFT: begin
          // A SYNC_n rise beats a coincident sampling edge, so a frame one bit short still errors.
          if (syncRise) begin
            frameError_q <= 1'b1;
            state_q      <= IDLE;
          end else if (sampleEdge) begin
            shift_q    <= shiftNext_d[12:0];
            bitCount_q <= bitCount_q + 5'd1;
            if (bitCount_q == 5'd15) begin
              outputSample_q <= shiftNext_d[11:0];
              outputMode_q   <= shiftNext_d[13:12];
              validPending_q <= 1'b1;
              state_q        <= DONE;
            end
          end
        end
        DONE: begin
          if (syncRise) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign outputSample = outputSample_q;
  assign outputMode   = outputMode_q;
  assign sampleValid  = sampleValid_q;
  assign frameError   = frameError_q;
  assign isReceiving  = (state_q == SHIFT);

`ifdef SPI_RX_FRAME_STATS_EN
  logic [15:0] goodCount_q;
  logic [15:0] errorCount_q;

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      goodCount_q  <= '0;
      errorCount_q <= '0;
    end else begin
      if (sampleValid_q) begin
        goodCount_q <= goodCount_q + 16'd1;
      end
      if (frameError_q) begin
        errorCount_q <= errorCount_q + 16'd1;
      end
    end
  end

  assign goodFrameCount  = goodCount_q;
  assign errorFrameCount = errorCount_q;
`endif

endmodule

// File: tb/tb_spi_dac_frame_receiver.sv
// Testbench for spi_dac_frame_receiver: random SPI frames compared against a frame-level reference model.
// Build with SPI_RX_FRAME_STATS_EN defined to also check the frame counters.
module tb_spi_dac_frame_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int LATENCY     = SYNC_STAGES + 2;

  logic        clock = 1'b0;
  logic        resetN;
  logic        spiSclk;
  logic        spiSyncN;
  logic        spiDin;
  logic [11:0] outputSample;
  logic [1:0]  outputMode;
  logic        sampleValid;
  logic        frameError;
  logic        isReceiving;
`ifdef SPI_RX_FRAME_STATS_EN
  logic [15:0] goodFrameCount;
  logic [15:0] errorFrameCount;
`endif

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;
  int validPulses = 0;
  int errorPulses = 0;
  int lastValidCycle = -1;
  int edgeCycle = 0;

  logic [11:0] modelSample = '0;
  logic [1:0]  modelMode = '0;
  int          modelGood = 0;
  int          modelErr = 0;

  spi_dac_frame_receiver #(
    .SAMPLE_ON_RISING(1),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clock_50Mhz(clock),
    .reset_n(resetN),
    .input_SPI_SCLK(spiSclk),
    .input_SPI_SYNC_n(spiSyncN),
    .input_SPI_DIN(spiDin),
    .outputSample(outputSample),
    .outputMode(outputMode),
    .sampleValid(sampleValid),
    .frameError(frameError),
    .isReceiving(isReceiving)
`ifdef SPI_RX_FRAME_STATS_EN
    ,
    .goodFrameCount(goodFrameCount),
    .errorFrameCount(errorFrameCount)
`endif
  );

  always #10 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Every cycle a pulse output is high counts once, so a stretched pulse shows up as an extra count.
  always @(negedge clock) begin
    if (sampleValid === 1'b1) begin
      validPulses++;
      lastValidCycle = cycleCnt;
    end
    if (frameError === 1'b1) begin
      errorPulses++;
    end
  end

  task automatic sendBits(input logic [15:0] word, input int nEdges, input bit collide, input bit leaveLow);
    int half;
    @(negedge clock);
    spiSclk  = 1'b0;
    spiSyncN = 1'b0;
    repeat (3 + $urandom_range(0, 3)) @(negedge clock);
    for (int i = 0; i < nEdges; i++) begin
      half = 3 + $urandom_range(0, 4);
      if (i < 16) spiDin = word[15-i];
      else spiDin = 1'($urandom_range(0, 1));
      repeat (half) @(negedge clock);
      spiSclk = 1'b1;
      if (i == 15) edgeCycle = cycleCnt;
      if (collide && i == nEdges - 1) spiSyncN = 1'b1;
      repeat (half) @(negedge clock);
      spiSclk = 1'b0;
    end
    repeat (3) @(negedge clock);
    if (!leaveLow) begin
      spiSyncN = 1'b1;
      repeat (SYNC_STAGES + 10) @(negedge clock);
    end
  endtask

  task automatic runFrame(input string name, input logic [15:0] word, input int nEdges, input bit collide);
    int v0;
    int e0;
    bit frameOk;
    v0 = validPulses;
    e0 = errorPulses;
    frameOk = collide ? (nEdges > 16) : (nEdges >= 16);
    sendBits(word, nEdges, collide, 1'b0);
    if (frameOk) begin
      modelSample = word[11:0];
      modelMode   = word[13:12];
      modelGood++;
    end else begin
      modelErr++;
    end
    checks++;
    if ((validPulses - v0) !== (frameOk ? 1 : 0)) begin
      failures++;
      $display("[TB] FAIL %s validPulses got=%0d exp=%0d", name, validPulses - v0, frameOk ? 1 : 0);
    end
    checks++;
    if ((errorPulses - e0) !== (frameOk ? 0 : 1)) begin
      failures++;
      $display("[TB] FAIL %s errorPulses got=%0d exp=%0d", name, errorPulses - e0, frameOk ? 0 : 1);
    end
    checks++;
    if (outputSample !== modelSample) begin
      failures++;
      $display("[TB] FAIL %s outputSample got=%h exp=%h", name, outputSample, modelSample);
    end
    checks++;
    if (outputMode !== modelMode) begin
      failures++;
      $display("[TB] FAIL %s outputMode got=%0d exp=%0d", name, outputMode, modelMode);
    end
    checks++;
    if (isReceiving !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s isReceiving after frame got=%b exp=0", name, isReceiving);
    end
    if (frameOk) begin
      checks++;
      if ((lastValidCycle - edgeCycle) !== LATENCY) begin
        failures++;
        $display("[TB] FAIL %s latency got=%0d exp=%0d", name, lastValidCycle - edgeCycle, LATENCY);
      end
    end
`ifdef SPI_RX_FRAME_STATS_EN
    checks++;
    if (goodFrameCount !== 16'(modelGood)) begin
      failures++;
      $display("[TB] FAIL %s goodFrameCount got=%0d exp=%0d", name, goodFrameCount, modelGood);
    end
    checks++;
    if (errorFrameCount !== 16'(modelErr)) begin
      failures++;
      $display("[TB] FAIL %s errorFrameCount got=%0d exp=%0d", name, errorFrameCount, modelErr);
    end
`endif
  endtask

  task automatic test_reset();
    resetN   = 1'b0;
    spiSclk  = 1'b0;
    spiSyncN = 1'b1;
    spiDin   = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({outputSample, outputMode, sampleValid, frameError, isReceiving} !== 17'd0) begin
      failures++;
      $display("[TB] FAIL reset outputs got=%h exp=0", {outputSample, outputMode, sampleValid, frameError, isReceiving});
    end
    resetN = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if ((validPulses + errorPulses) !== 0) begin
      failures++;
      $display("[TB] FAIL reset_release pulses got=%0d exp=0", validPulses + errorPulses);
    end
  endtask

  task automatic test_basic_frames();
    runFrame("frame_0ABC", 16'h0ABC, 16, 1'b0);
  endtask

  task automatic test_short_frame();
    runFrame("short_9", 16'h1234, 9, 1'b0);
  endtask

  task automatic test_dont_care_bits();
    runFrame("frame_F123", 16'hF123, 16, 1'b0);
  endtask

  task automatic test_extra_edges();
    runFrame("extra_edges_0555", 16'h0555, 20, 1'b0);
  endtask

  task automatic test_collision();
    runFrame("collide_16th", 16'h2DEF, 16, 1'b1);
    runFrame("collide_17th", 16'h1357, 17, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      runFrame($sformatf("random_%0d", k), 16'($urandom), int'($urandom_range(1, 20)), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    runFrame("loopback_800", 16'h0800, 16, 1'b0);
    runFrame("loopback_7FF", 16'h07FF, 16, 1'b0);
  endtask

  task automatic test_mid_frame_reset();
    int e0;
    e0 = errorPulses;
    sendBits(16'h0FFF, 8, 1'b0, 1'b1);
    checks++;
    if (isReceiving !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset isReceiving got=%b exp=1", isReceiving);
    end
    #3 resetN = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({outputSample, outputMode, sampleValid, frameError, isReceiving} !== 17'd0) begin
      failures++;
      $display("[TB] FAIL midreset outputs got=%h exp=0", {outputSample, outputMode, sampleValid, frameError, isReceiving});
    end
    spiSyncN = 1'b1;
    spiSclk  = 1'b0;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    modelSample = '0;
    modelMode   = '0;
    modelGood   = 0;
    modelErr    = 0;
    repeat (6) @(negedge clock);
    checks++;
    if ((errorPulses - e0) !== 0) begin
      failures++;
      $display("[TB] FAIL midreset errorPulses got=%0d exp=0", errorPulses - e0);
    end
    runFrame("after_reset_0001", 16'h0001, 16, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_frames();
    test_short_frame();
    test_dont_care_bits();
    test_extra_edges();
    test_collision();
    test_random();
    test_back_to_back();
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
